// File: rtl/cbf_pkg.sv
// cbf_pkg: shared width helpers and channel slicing
// for the N-channel CBF power estimator.
package cbf_pkg;

  // Width of one conjugate product term (I or Q).
  function automatic int cmul_w(input int wl_iq);
    return 2 * wl_iq + 1;
  endfunction

  // Beam-sum width: one extra bit per tree level.
  function automatic int wl_y_f(input int num_ch,
                                input int wl_iq);
    return cmul_w(wl_iq) + $clog2(num_ch);
  endfunction

  // |y|^2 width, also the width of the mean.
  function automatic int wl_p_f(input int num_ch,
                                input int wl_iq);
    return 2 * wl_y_f(num_ch, wl_iq);
  endfunction

  // MSB index of channel k's I component.
  function automatic int i_off(input int k,
                               input int wl_iq);
    return (2 * k + 1) * wl_iq - 1;
  endfunction

  // MSB index of channel k's Q component.
  function automatic int q_off(input int k,
                               input int wl_iq);
    return (2 * k + 2) * wl_iq - 1;
  endfunction

  localparam int WL_Y_DEF = wl_y_f(4, 16);
  localparam int WL_P_DEF = wl_p_f(4, 16);

endpackage

// File: rtl/cbf_cmul_conj.sv
// cbf_cmul_conj: registered conj(s)*x for one channel.
// Ports: clk, rst (async low), en, s_i/s_q, x_i/x_q in; y_i/y_q out.
module cbf_cmul_conj
  import cbf_pkg::*;
#(
  parameter int WL_IQ = 16,
  localparam int CW = cmul_w(WL_IQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [WL_IQ-1:0] s_i,
  input  logic signed [WL_IQ-1:0] s_q,
  input  logic signed [WL_IQ-1:0] x_i,
  input  logic signed [WL_IQ-1:0] x_q,
  output logic signed [CW-1:0]    y_i,
  output logic signed [CW-1:0]    y_q
);

  logic signed [CW-1:0] si, sq, xi, xq;

  assign si = CW'(s_i);
  assign sq = CW'(s_q);
  assign xi = CW'(x_i);
  assign xq = CW'(x_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_i <= '0;
      y_q <= '0;
    end else if (en) begin
      y_i <= si * xi + sq * xq;
      y_q <= si * xq - sq * xi;
    end
  end

endmodule

// File: rtl/cbf_power_estimator_nch.sv
// cbf_power_estimator_nch: NUM_CH beamformer, |y|^2, moving mean
// over 2^AVG_LOG2 beats, AXI-stream in/out with backpressure.
// Ports: clk, rst (async low), s_axis_* in, m_axis_* out,
// w_data/w_load steering load + flush, win_full status.
// Option: CBF_PEAK_HOLD_EN adds peak_power (max mean since flush).
module cbf_power_estimator_nch
  import cbf_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int WL_IQ    = 16,
  parameter int AVG_LOG2 = 3,
  localparam int WL_Y    = wl_y_f(NUM_CH, WL_IQ),
  localparam int WL_P    = wl_p_f(NUM_CH, WL_IQ),
  localparam int DW      = NUM_CH * 2 * WL_IQ
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   s_axis_tdata,
  input  logic            s_axis_tvalid,
  output logic            s_axis_tready,
  output logic [WL_P-1:0] m_axis_tdata,
  output logic            m_axis_tvalid,
  input  logic            m_axis_tready,
  input  logic [DW-1:0]   w_data,
  input  logic            w_load,
  output logic            win_full
`ifdef CBF_PEAK_HOLD_EN
  ,
  output logic [WL_P-1:0] peak_power
`endif
);

  localparam int CW    = cmul_w(WL_IQ);
  localparam int W     = 1 << AVG_LOG2;
  localparam int SW    = WL_P + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;

  logic adv;

  assign adv           = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = adv;

  // Steering weights
  logic [DW-1:0] w_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        w_q <= '0;
    else if (w_load) w_q <= w_data;
  end

  // Pipeline valids; w_load drops every in-flight beat
  logic v1, v2, v3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (w_load) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (adv) begin
      v1 <= s_axis_tvalid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // Stage 1: conjugate multiply per channel
  logic signed [CW-1:0] c_i [NUM_CH];
  logic signed [CW-1:0] c_q [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    cbf_cmul_conj #(
      .WL_IQ (WL_IQ)
    ) u_cmul (
      .clk (clk),
      .rst (rst),
      .en  (adv),
      .s_i (w_q[i_off(k, WL_IQ) -: WL_IQ]),
      .s_q (w_q[q_off(k, WL_IQ) -: WL_IQ]),
      .x_i (s_axis_tdata[i_off(k, WL_IQ) -: WL_IQ]),
      .x_q (s_axis_tdata[q_off(k, WL_IQ) -: WL_IQ]),
      .y_i (c_i[k]),
      .y_q (c_q[k])
    );
  end

  // Stage 2: channel sum
  logic signed [WL_Y-1:0] sum_i_c, sum_q_c;
  logic signed [WL_Y-1:0] y_i, y_q;

  always_comb begin
    sum_i_c = '0;
    sum_q_c = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum_i_c = sum_i_c + WL_Y'(c_i[k]);
      sum_q_c = sum_q_c + WL_Y'(c_q[k]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_i <= '0;
      y_q <= '0;
    end else if (adv) begin
      y_i <= sum_i_c;
      y_q <= sum_q_c;
    end
  end

  // Stage 3: |y|^2; each square fits signed WL_P,
  // the sum only fits once read as unsigned
  logic signed [WL_P-1:0] sq_i, sq_q;
  logic [WL_P-1:0]        p_c, p;

  assign sq_i = WL_P'(y_i) * WL_P'(y_i);
  assign sq_q = WL_P'(y_q) * WL_P'(y_q);
  assign p_c  = $unsigned(sq_i) + $unsigned(sq_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     p <= '0;
    else if (adv) p <= p_c;
  end

  // Stage 4: running window sum
  logic [SW-1:0] sum_n;

  if (AVG_LOG2 > 0) begin : g_hist
    logic [WL_P-1:0]     hist [W];
    logic [AVG_LOG2-1:0] ptr;
    logic [SW-1:0]       sum_q;

    assign sum_n = sum_q + SW'(p) - SW'(hist[ptr]);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < W; i++) hist[i] <= '0;
        ptr   <= '0;
        sum_q <= '0;
      end else if (w_load) begin
        for (int i = 0; i < W; i++) hist[i] <= '0;
        ptr   <= '0;
        sum_q <= '0;
      end else if (adv && v3) begin
        hist[ptr] <= p;
        ptr       <= ptr + 1'b1;
        sum_q     <= sum_n;
      end
    end
  end else begin : g_nohist
    assign sum_n = SW'(p);
  end

  // Fill counter and output register
  logic [CNT_W-1:0] fill, fill_n;

  assign fill_n   = (fill == CNT_W'(W)) ? fill
                                        : fill + 1'b1;
  assign win_full = (fill == CNT_W'(W));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill          <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (w_load) begin
      fill          <= '0;
      m_axis_tvalid <= 1'b0;
    end else if (adv) begin
      m_axis_tvalid <= v3 && (fill_n == CNT_W'(W));
      if (v3) begin
        fill         <= fill_n;
        m_axis_tdata <= WL_P'(sum_n >> AVG_LOG2);
      end
    end
  end

`ifdef CBF_PEAK_HOLD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      peak_power <= '0;
    else if (w_load)
      peak_power <= '0;
    else if (m_axis_tvalid && m_axis_tready &&
             m_axis_tdata > peak_power)
      peak_power <= m_axis_tdata;
  end
`endif

endmodule

// File: tb/tb_cbf_power_estimator_nch.sv
// tb_cbf_power_estimator_nch: scoreboard bench with a
// queue-based window model of the beamformed mean power.
`timescale 1ns/1ps
module tb_cbf_power_estimator_nch;

  localparam int NCH = 4;
  localparam int WIQ = 16;
  localparam int L   = 3;
  localparam int W   = 1 << L;
  localparam int DW  = NCH * 2 * WIQ;
  localparam int WP  = 2 * (2 * WIQ + 1 + $clog2(NCH));

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [WP-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          w_load = 1'b0;
  logic          win_full;
`ifdef CBF_PEAK_HOLD_EN
  logic [WP-1:0] peak_power;
`endif

  always #5 clk = ~clk;

  cbf_power_estimator_nch #(
    .NUM_CH   (NCH),
    .WL_IQ    (WIQ),
    .AVG_LOG2 (L)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .w_data        (w_data),
    .w_load        (w_load),
    .win_full      (win_full)
`ifdef CBF_PEAK_HOLD_EN
    ,
    .peak_power    (peak_power)
`endif
  );

  logic [127:0] exp_q [$];
  logic [127:0] hist  [$];
  longint       mwi [NCH];
  longint       mwq [NCH];
  logic [127:0] peak_m = '0;
  int           tot = 0;
  int           bad = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] req);
    tot++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  function automatic logic [DW-1:0] pack(input int i,
                                         input int q,
                                         input int n);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < n; k++) begin
      r[(2*k+1)*WIQ-1 -: WIQ] = WIQ'(i);
      r[(2*k+2)*WIQ-1 -: WIQ] = WIQ'(q);
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++)
      r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic set_w(input logic [DW-1:0] wd);
    for (int k = 0; k < NCH; k++) begin
      mwi[k] = longint'($signed(wd[(2*k+1)*WIQ-1 -: WIQ]));
      mwq[k] = longint'($signed(wd[(2*k+2)*WIQ-1 -: WIQ]));
    end
  endtask

  task automatic flush();
    exp_q.delete();
    hist.delete();
    peak_m = '0;
  endtask

  // Reference: y = sum conj(w)*x, p = |y|^2, mean of last W p
  task automatic model_beat(input logic [DW-1:0] x);
    longint              xi, xq, yi, yq;
    logic signed [127:0] bi, bq;
    logic [127:0]        s;
    yi = 0;
    yq = 0;
    for (int k = 0; k < NCH; k++) begin
      xi = longint'($signed(x[(2*k+1)*WIQ-1 -: WIQ]));
      xq = longint'($signed(x[(2*k+2)*WIQ-1 -: WIQ]));
      yi += mwi[k] * xi + mwq[k] * xq;
      yq += mwi[k] * xq - mwq[k] * xi;
    end
    bi = yi;
    bq = yq;
    hist.push_back(bi * bi + bq * bq);
    if (hist.size() > W) void'(hist.pop_front());
    if (hist.size() == W) begin
      s = '0;
      foreach (hist[i]) s += hist[i];
      exp_q.push_back(s >> L);
    end
  endtask

  task automatic cyc(input logic          v,
                     input logic [DW-1:0] x,
                     input logic          ld,
                     input logic [DW-1:0] wd,
                     input logic          rdy);
    @(posedge clk);
    #1;
    s_tvalid = v;
    s_tdata  = x;
    w_load   = ld;
    w_data   = wd;
    m_tready = rdy;
    @(negedge clk);
    #1;
    if (ld) begin
      flush();
      set_w(wd);
    end else if (v && s_tready) begin
      model_beat(x);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, 1'b1);
  endtask

  // Monitor: handshake pops, stall stability, ready rule
  logic [WP-1:0] held;
  logic          hv = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      chk("s_tready", s_tready, !m_tvalid || m_tready);
      if (hv && m_tvalid) chk("stall_hold", m_tdata, held);
      hv   = m_tvalid && !m_tready;
      held = m_tdata;
`ifdef CBF_PEAK_HOLD_EN
      chk("peak_power", peak_power, peak_m);
`endif
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          tot++;
          bad++;
          $display("FAIL unexpected_beat: got %0d want none",
                   m_tdata);
        end else begin
          chk("m_tdata", m_tdata, exp_q.pop_front());
          chk("win_full_on_beat", win_full, 1'b1);
          if (128'(m_tdata) > peak_m) peak_m = 128'(m_tdata);
        end
      end
    end else begin
      hv = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NCH; k++) begin
      mwi[k] = 0;
      mwq[k] = 0;
    end
    #2;
    chk("rst_tvalid", m_tvalid, 1'b0);
    chk("rst_tdata", m_tdata, '0);
    chk("rst_full", win_full, 1'b0);
    chk("rst_tready", s_tready, 1'b1);
    #20 rst = 1'b1;

    // w=(1,0), x=(1000,0): first beat after 8 inputs + 4
    cyc(1'b0, '0, 1'b1, pack(1, 0, NCH), 1'b1);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, pack(1000, 0, NCH), 1'b0, '0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, '0, 1'b0, '0, 1'b1);
      chk("lat_valid", m_tvalid, i == 4);
      chk("lat_full", win_full, i == 4);
    end
    for (int i = 0; i < 4; i++)
      cyc(1'b1, '0, 1'b0, '0, 1'b1);
    idle(6);

    // conjugate check on channel 0 only
    cyc(1'b0, '0, 1'b1, pack(0, 1, 1), 1'b1);
    for (int i = 0; i < 10; i++)
      cyc(1'b1, pack(0, 1000, 1), 1'b0, '0, 1'b1);
    idle(6);

    // backpressure mid-stream
    for (int i = 0; i < 12; i++)
      cyc(1'b1, rnd(), 1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++)
      cyc(1'b1, rnd(), 1'b0, '0, 1'b0);
    chk("stall_tvalid", m_tvalid, 1'b1);
    chk("stall_sready", s_tready, 1'b0);
    for (int i = 0; i < 10; i++)
      cyc(1'b1, rnd(), 1'b0, '0, 1'b1);

    // reload mid-stream
    cyc(1'b1, rnd(), 1'b1, rnd(), 1'b1);
    cyc(1'b1, rnd(), 1'b0, '0, 1'b1);
    chk("ld_tvalid", m_tvalid, 1'b0);
    chk("ld_full", win_full, 1'b0);
    for (int i = 0; i < 12; i++)
      cyc(1'b1, rnd(), 1'b0, '0, 1'b1);
    idle(6);

    // extreme values, exact wide result
    cyc(1'b0, '0, 1'b1, pack(-32768, -32768, NCH), 1'b1);
    for (int i = 0; i < 10; i++)
      cyc(1'b1, pack(-32768, -32768, NCH), 1'b0, '0, 1'b1);
    idle(6);

    // random traffic, stalls and reloads
    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 3) != 0, rnd(),
          $urandom_range(0, 59) == 0, rnd(),
          $urandom_range(0, 9) < 7);

    // async reset mid-stream
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_tvalid", m_tvalid, 1'b0);
    chk("arst_tdata", m_tdata, '0);
    chk("arst_full", win_full, 1'b0);
    flush();
    for (int k = 0; k < NCH; k++) begin
      mwi[k] = 0;
      mwq[k] = 0;
    end
    s_tvalid = 1'b0;
    w_load   = 1'b0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    cyc(1'b0, '0, 1'b1, pack(3, -2, NCH), 1'b1);
    for (int i = 0; i < 12; i++)
      cyc(1'b1, rnd(), 1'b0, '0, 1'b1);
    idle(8);
    chk("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
